product_serializer: RTL and testbench

PRODUCT_SERIALIZER -- requirements
Module: product_serializer

---
 rtl/product_serializer_pkg.sv | 23 ++
 rtl/product_serializer_if.sv | 37 +++
 rtl/serializer_bit_counter.sv | 39 +++
 rtl/product_serializer.sv | 102 ++++++++++
 tb/tb_product_serializer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/product_serializer_pkg.sv
// ---------------------------------------------------------------------------
// product_serializer_pkg
// Shared definitions for the multiplier product serializer: the default
// word width (product width of the 4x4 multiplier), the FSM state encoding
// and a helper that sizes the bit counter.
// No ports (package).
// ---------------------------------------------------------------------------
package product_serializer_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // The counter has to be able to hold the value WIDTH, so it gets
    // ceil(log2(WIDTH+1)) bits.
    function automatic int cntWidth(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/product_serializer_if.sv
// ---------------------------------------------------------------------------
// product_serializer_if
// Groups the parallel-load and serial-output handshake of the serializer.
//   in         : parallel word, sampled on an accepted load
//   load       : load request, honoured only while not busy
//   ready      : downstream takes the current serial bit this cycle
//   sout       : serial data bit, LSB first
//   sout_valid : sout holds a valid bit
//   busy       : a word is in flight
//   done       : one-cycle pulse after the final bit transfers
// Modports: master (word source / bit sink), slave (the serializer).
// ---------------------------------------------------------------------------
interface product_serializer_if
    import product_serializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);

    logic [WIDTH-1:0] in;
    logic             load;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    modport master (
        output in, load, ready,
        input  sout, sout_valid, busy, done
    );

    modport slave (
        input  in, load, ready,
        output sout, sout_valid, busy, done
    );

endinterface

// File: rtl/serializer_bit_counter.sv
// ---------------------------------------------------------------------------
// serializer_bit_counter
// Counts transferred bits of the current word.
//   clk  : rising-edge clock
//   clr  : synchronous active-high clear (reset or start/end of a word)
//   en_i : count enable, one per transferred bit
//   tc_o : terminal count, high while the counter sits on LAST
// ---------------------------------------------------------------------------
module serializer_bit_counter #(
    parameter int CW   = 4,
    parameter int LAST = 7
) (
    input  logic clk,
    input  logic clr,
    input  logic en_i,
    output logic tc_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == CW'(LAST));

endmodule

// File: rtl/product_serializer.sv
// ---------------------------------------------------------------------------
// product_serializer
// Loads a parallel multiplier product and shifts it out LSB first under a
// valid/ready handshake, pulsing done for one cycle after the last bit.
//   clk : rising-edge clock
//   clr : synchronous active-high reset
//   bus : product_serializer_if.slave (in, load, ready, sout, sout_valid,
//         busy, done)
// Optional build macro SERIALIZER_PARITY_EN appends an even-parity bit
// (XOR of the captured word) after bit WIDTH-1.
// ---------------------------------------------------------------------------
module product_serializer
    import product_serializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                clr,
    product_serializer_if.slave bus
);

`ifdef SERIALIZER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = cntWidth(WIDTH);

    state_t           state_q, state_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic             done_q, done_d;
    logic             cntClear;
    logic             cntEn;
    logic             cntTc;

    // Next-state logic. In SHIFT a transfer happens whenever ready is high
    // because sout_valid is always asserted there. The counter is cleared on
    // the final transfer as well, so it rests at zero between words.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        done_d   = 1'b0;
        cntClear = 1'b0;
        cntEn    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
`ifdef SERIALIZER_PARITY_EN
                    shift_d = {^bus.in, bus.in};
`else
                    shift_d = bus.in;
`endif
                    cntClear = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.ready) begin
                    shift_d = shift_q >> 1;
                    cntEn   = 1'b1;
                    if (cntTc) begin
                        cntClear = 1'b1;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, data and done registers; clr wins over everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            shift_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            done_q  <= done_d;
        end
    end

    serializer_bit_counter #(
        .CW   (CW),
        .LAST (NBITS - 1)
    ) u_bitCounter (
        .clk  (clk),
        .clr  (clr | cntClear),
        .en_i (cntEn),
        .tc_o (cntTc)
    );

    assign bus.busy       = (state_q == SHIFT);
    assign bus.sout_valid = (state_q == SHIFT);
    assign bus.sout       = (state_q == SHIFT) & shift_q[0];
    assign bus.done       = done_q;

endmodule

// File: tb/tb_product_serializer.sv
// ---------------------------------------------------------------------------
// tb_product_serializer
// Randomised and directed stimulus for product_serializer, checked every
// cycle against a queue-of-bits reference model, plus literal expectations
// for the reference words.
// ---------------------------------------------------------------------------
module tb_product_serializer;
    import product_serializer_pkg::*;

`ifdef SERIALIZER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic clk;
    logic clr;
    int   checks;
    int   errors;

    bit   expQ[$];
    bit   expDone;
    bit   modelValid;

    bit   rxLog[4096];
    int   rxCount;

    product_serializer_if #(.WIDTH(8)) bus ();

    product_serializer #(.WIDTH(8)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and report mismatches.
    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is just a queue of bits still to send.
    task automatic updateModel();
        bit newDone;
        newDone = 1'b0;
        if (clr) begin
            expQ.delete();
            modelValid = 1'b1;
        end else if (expQ.size() == 0) begin
            if (bus.load) begin
                for (int i = 0; i < 8; i++) expQ.push_back(bus.in[i]);
`ifdef SERIALIZER_PARITY_EN
                expQ.push_back(^bus.in);
`endif
            end
        end else if (bus.ready) begin
            void'(expQ.pop_front());
            if (expQ.size() == 0) newDone = 1'b1;
        end
        expDone = newDone;
    endtask

    // Per-cycle comparison of all outputs against the model.
    task automatic compareModel();
        if (modelValid) begin
            checkOutput("busy", 16'(bus.busy), 16'(expQ.size() != 0));
            checkOutput("sout_valid", 16'(bus.sout_valid), 16'(expQ.size() != 0));
            checkOutput("sout", 16'(bus.sout), 16'((expQ.size() != 0) ? expQ[0] : 1'b0));
            checkOutput("done", 16'(bus.done), 16'(expDone));
        end
    endtask

    // One clock cycle: check, drive, log the bit about to transfer, clock,
    // advance the model.
    task automatic applyStimulus(input logic l, input logic [7:0] d, input logic r, input logic c);
        @(negedge clk);
        compareModel();
        bus.load  = l;
        bus.in    = d;
        bus.ready = r;
        clr       = c;
        if (bus.sout_valid && r && !c && rxCount < 4096) begin
            rxLog[rxCount] = bus.sout;
            rxCount++;
        end
        @(posedge clk);
        updateModel();
        #1;
    endtask

    // Step until done appears, with ready held high or toggling 1,0,1,0...
    task automatic runUntilDone(input logic l, input logic [7:0] d, input bit toggle);
        for (int k = 0; k < 64; k++) begin
            if (bus.done === 1'b1) break;
            applyStimulus(l, d, toggle ? (k % 2 == 0) : 1'b1, 1'b0);
        end
        checkOutput("doneSeen", 16'(bus.done), 16'h1);
    endtask

    function automatic logic [15:0] gotWord(input int start, input int n);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < n; i++) begin
            if (start + i < 4096) w[i] = rxLog[start + i];
        end
        return w;
    endfunction

    function automatic logic [15:0] expWord(input logic [7:0] d);
`ifdef SERIALIZER_PARITY_EN
        return {7'b0, ^d, d};
`else
        return {8'h00, d};
`endif
    endfunction

    initial begin
        logic [7:0] pat;
        int         start;
        int         start2;
        checks     = 0;
        errors     = 0;
        rxCount    = 0;
        expDone    = 1'b0;
        modelValid = 1'b0;
        clr        = 1'b1;
        bus.load   = 1'b0;
        bus.in     = '0;
        bus.ready  = 1'b0;

        // Reset state
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("rstBusy", 16'(bus.busy), 16'h0);
        checkOutput("rstValid", 16'(bus.sout_valid), 16'h0);
        checkOutput("rstDone", 16'(bus.done), 16'h0);
        checkOutput("rstSout", 16'(bus.sout), 16'h0);

        // clr coincident with load: the word is not captured
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1);
        checkOutput("clrLoadBusy", 16'(bus.busy), 16'h0);

        // 8'hA5 with ready high: literal bit sequence, then done
        pat = 8'hA5;
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < NB; i++) begin
            checkOutput("a5Bit", 16'(bus.sout), 16'((i < 8) ? pat[i] : 1'b0));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("a5Done", 16'(bus.done), 16'h1);
        checkOutput("a5Busy", 16'(bus.busy), 16'h0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("a5DoneOnce", 16'(bus.done), 16'h0);

        // 8'h3C with ready toggling
        start = rxCount;
        applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0);
        runUntilDone(1'b0, 8'h00, 1'b1);
        checkOutput("w3C", gotWord(start, NB), expWord(8'h3C));
        checkOutput("w3Clen", 16'(rxCount - start), 16'(NB));

        // Load of 8'hFF during 8'h0F is ignored
        start = rxCount;
        applyStimulus(1'b1, 8'h0F, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
        runUntilDone(1'b0, 8'h00, 1'b0);
        checkOutput("w0F", gotWord(start, 8), 16'h000F);
        checkOutput("w0Flen", 16'(rxCount - start), 16'(NB));
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("w0FIdle", 16'(bus.busy), 16'h0);

        // clr after three bits of 8'h96, then a clean 8'h01
        start = rxCount;
        applyStimulus(1'b1, 8'h96, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("w96Part", gotWord(start, 3), 16'h0006);
        checkOutput("clrValid", 16'(bus.sout_valid), 16'h0);
        checkOutput("clrBusy", 16'(bus.busy), 16'h0);
        checkOutput("clrDone", 16'(bus.done), 16'h0);
        start = rxCount;
        applyStimulus(1'b1, 8'h01, 1'b1, 1'b0);
        runUntilDone(1'b0, 8'h00, 1'b0);
        checkOutput("w01", gotWord(start, NB), expWord(8'h01));

        // Back-to-back 8'h81 then 8'h7E with load held
        start = rxCount;
        applyStimulus(1'b1, 8'h81, 1'b1, 1'b0);
        runUntilDone(1'b1, 8'h81, 1'b0);
        checkOutput("w81", gotWord(start, NB), expWord(8'h81));
        start2 = rxCount;
        applyStimulus(1'b1, 8'h7E, 1'b1, 1'b0);
        checkOutput("b2bBusy", 16'(bus.busy), 16'h1);
        runUntilDone(1'b0, 8'h00, 1'b0);
        checkOutput("w7E", gotWord(start2, NB), expWord(8'h7E));

`ifdef SERIALIZER_PARITY_EN
        // Parity words with literal expectations
        start = rxCount;
        applyStimulus(1'b1, 8'h07, 1'b1, 1'b0);
        runUntilDone(1'b0, 8'h00, 1'b0);
        checkOutput("par07", gotWord(start, 9), 16'h0107);
        start = rxCount;
        applyStimulus(1'b1, 8'h03, 1'b1, 1'b0);
        runUntilDone(1'b0, 8'h00, 1'b0);
        checkOutput("par03", gotWord(start, 9), 16'h0003);
`endif

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            applyStimulus(logic'($urandom_range(0, 3) == 0),
                          8'($urandom_range(0, 255)),
                          logic'($urandom_range(0, 2) != 0),
                          logic'($urandom_range(0, 63) == 0));
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
